// File: rtl/dnd_event_gate.sv
// Event gate after the denoise MLP: buffers accepted events, pairs each with its
// later score in order, forwards passing events and drops noise, with stats/errors.
module dnd_event_gate #(
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int W_Y             = 16,
  parameter int DEPTH           = 8,
  parameter int W_CNT           = 16,
  localparam int W_EV           = 2*CAVIAR_X_Y_BITS+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_EV-1:0]  ev_in,
  input  logic             ev_in_vld,
  output logic             ev_in_rdy,
  input  logic [W_Y-1:0]   score,
  input  logic             score_vld,
  input  logic [W_Y-1:0]   threshold,
  input  logic             bypass,
  output logic [W_EV-1:0]  ev_out,
  output logic             ev_out_vld,
  input  logic             ev_out_rdy,
  output logic [W_CNT-1:0] pass_cnt,
  output logic [W_CNT-1:0] drop_cnt,
  output logic             err_overflow,
  output logic             err_orphan
);

  localparam int W_IDX = $clog2(DEPTH);
  localparam int W_PTR = W_IDX + 1;

  logic [W_EV-1:0]  r_ev   [DEPTH];
  logic [DEPTH-1:0] r_dec;
  logic [DEPTH-1:0] r_pass;
  logic [W_PTR-1:0] r_wr_ptr, r_sc_ptr, r_rd_ptr;
  logic [W_CNT-1:0] r_pass_cnt, r_drop_cnt;
  logic             r_err_overflow, r_err_orphan;
  logic             r_run;

  logic [W_PTR-1:0] w_used, w_undec;
  logic [W_IDX-1:0] w_wr_idx, w_sc_idx, w_rd_idx;
  logic             w_full, w_empty, w_head_dec, w_head_pass;
  logic             w_push, w_decide, w_pass_pop, w_drop, w_score_ok;

  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_undec     = r_wr_ptr - r_sc_ptr;
  assign w_full      = (w_used == W_PTR'(DEPTH));
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_wr_idx    = r_wr_ptr[W_IDX-1:0];
  assign w_sc_idx    = r_sc_ptr[W_IDX-1:0];
  assign w_rd_idx    = r_rd_ptr[W_IDX-1:0];
  assign w_head_dec  = !w_empty && r_dec[w_rd_idx];
  assign w_head_pass = r_pass[w_rd_idx];

  // r_run keeps ready low for the first cycle after reset release.
  assign ev_in_rdy   = r_run && !w_full;
  assign w_push      = ev_in_vld && ev_in_rdy;
  assign w_decide    = score_vld && (w_undec != '0);
  assign w_score_ok  = bypass || ($signed(score) >= $signed(threshold));
  assign w_pass_pop  = w_head_dec && w_head_pass && ev_out_rdy;
  assign w_drop      = w_head_dec && !w_head_pass;

  assign ev_out_vld  = w_head_dec && w_head_pass;
  assign ev_out      = ev_out_vld ? r_ev[w_rd_idx] : '0;

  assign pass_cnt     = r_pass_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign err_overflow = r_err_overflow;
  assign err_orphan   = r_err_orphan;

  // Event payload needs no reset; validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_ev[w_wr_idx] <= ev_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec          <= '0;
      r_pass         <= '0;
      r_wr_ptr       <= '0;
      r_sc_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_pass_cnt     <= '0;
      r_drop_cnt     <= '0;
      r_err_overflow <= 1'b0;
      r_err_orphan   <= 1'b0;
      r_run          <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_push) begin
        r_dec[w_wr_idx] <= 1'b0;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (ev_in_vld && w_full) r_err_overflow <= 1'b1;
      if (w_decide) begin
        r_dec[w_sc_idx]  <= 1'b1;
        r_pass[w_sc_idx] <= w_score_ok;
        r_sc_ptr         <= r_sc_ptr + 1'b1;
      end
      if (score_vld && !w_decide) r_err_orphan <= 1'b1;
      if (w_pass_pop || w_drop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_pass_pop && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dnd_event_gate.sv
// Directed bench for dnd_event_gate: pass/drop, ordering under backpressure,
// simultaneous push/decide/pop, error flags, bypass and counter saturation.
module tb_dnd_event_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] ev_in;
  logic        ev_in_vld;
  logic        ev_in_rdy;
  logic [15:0] score;
  logic        score_vld;
  logic [15:0] threshold;
  logic        bypass;
  logic [18:0] ev_out;
  logic        ev_out_vld;
  logic        ev_out_rdy;
  logic [15:0] pass_cnt;
  logic [15:0] drop_cnt;
  logic        err_overflow;
  logic        err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dnd_event_gate dut (
    .clk(clk), .rst_n(rst_n),
    .ev_in(ev_in), .ev_in_vld(ev_in_vld), .ev_in_rdy(ev_in_rdy),
    .score(score), .score_vld(score_vld), .threshold(threshold), .bypass(bypass),
    .ev_out(ev_out), .ev_out_vld(ev_out_vld), .ev_out_rdy(ev_out_rdy),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt),
    .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  task automatic do_reset;
    rst_n = 1'b0; ev_in_vld = 1'b0; score_vld = 1'b0; ev_out_rdy = 1'b1;
    bypass = 1'b0; ev_in = '0; score = '0; threshold = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_ev(input logic [18:0] v);
    ev_in = v; ev_in_vld = 1'b1;
    @(negedge clk);
    ev_in_vld = 1'b0;
  endtask

  task automatic send_score(input logic [15:0] s, input logic [15:0] th);
    score = s; threshold = th; score_vld = 1'b1;
    @(negedge clk);
    score_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ev_out_vld !== 1'b0 || ev_out !== 19'h0) begin
      n_fail++; $display("FAIL reset_out: vld=%b ev=%h, want 0/0", ev_out_vld, ev_out);
    end
    do_reset();
    n_checks++;
    if (ev_in_rdy !== 1'b1 || pass_cnt !== 16'h0 || drop_cnt !== 16'h0 ||
        err_overflow !== 1'b0 || err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b pass=%h drop=%h ovf=%b orph=%b, want 1/0/0/0/0",
               ev_in_rdy, pass_cnt, drop_cnt, err_overflow, err_orphan);
    end
  endtask

  task automatic test_single_pass;
    do_reset();
    push_ev(19'h12345);
    repeat (19) @(negedge clk);
    n_checks++;
    if (ev_out_vld !== 1'b0) begin
      n_fail++; $display("FAIL single_wait: vld=%b, want 0", ev_out_vld);
    end
    send_score(16'd100, 16'd50);
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h12345) begin
      n_fail++; $display("FAIL single_out: vld=%b ev=%h, want 1/12345", ev_out_vld, ev_out);
    end
    @(negedge clk);
    n_checks++;
    if (pass_cnt !== 16'd1 || ev_out_vld !== 1'b0 || ev_out !== 19'h0) begin
      n_fail++;
      $display("FAIL single_pop: pass=%0d vld=%b ev=%h, want 1/0/0", pass_cnt, ev_out_vld, ev_out);
    end
  endtask

  task automatic test_noise_drop;
    do_reset();
    push_ev(19'h00777);
    send_score(16'hFFFD, 16'h0000);
    n_checks++;
    if (ev_out_vld !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL drop_head: vld=%b drop=%0d, want 0/0", ev_out_vld, drop_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (drop_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
      n_fail++; $display("FAIL drop_cnt: drop=%0d pass=%0d, want 1/0", drop_cnt, pass_cnt);
    end
    push_ev(19'h00888);
    send_score(16'hFFF9, 16'hFFF9);
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h00888) begin
      n_fail++; $display("FAIL equal_pass: vld=%b ev=%h, want 1/00888", ev_out_vld, ev_out);
    end
    @(negedge clk);
  endtask

  task automatic test_ordering;
    logic [18:0] got [8];
    int n = 0;
    do_reset();
    ev_out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_ev(19'h00100 + 19'(i));
    n_checks++;
    if (ev_in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL order_full: rdy=%b, want 0", ev_in_rdy);
    end
    for (int i = 0; i < 8; i++) send_score((i % 2 == 0) ? 16'd10 : 16'hFFF6, 16'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h00100 || pass_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL order_hold: vld=%b ev=%h pass=%0d drop=%0d, want 1/00100/0/0",
               ev_out_vld, ev_out, pass_cnt, drop_cnt);
    end
    ev_out_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (ev_out_vld === 1'b1 && n < 8) begin got[n] = ev_out; n++; end
      @(negedge clk);
    end
    n_checks++;
    if (n != 4) begin
      n_fail++; $display("FAIL order_count: got %0d events, want 4", n);
    end
    for (int k = 0; k < 4 && k < n; k++) begin
      n_checks++;
      if (got[k] !== 19'h00100 + 19'(2*k)) begin
        n_fail++; $display("FAIL order_val%0d: ev=%h, want %h", k, got[k], 19'h00100 + 19'(2*k));
      end
    end
    n_checks++;
    if (pass_cnt !== 16'd4 || drop_cnt !== 16'd4 || ev_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL order_end: pass=%0d drop=%0d rdy=%b, want 4/4/1", pass_cnt, drop_cnt, ev_in_rdy);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    ev_out_rdy = 1'b0;
    push_ev(19'h00AAA);
    push_ev(19'h00BBB);
    send_score(16'd5, 16'd0);
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h00AAA) begin
      n_fail++; $display("FAIL simul_head: vld=%b ev=%h, want 1/00AAA", ev_out_vld, ev_out);
    end
    ev_in = 19'h00CCC; ev_in_vld = 1'b1;
    score = 16'd5; threshold = 16'd0; score_vld = 1'b1;
    ev_out_rdy = 1'b1;
    @(negedge clk);
    ev_in_vld = 1'b0;
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h00BBB || pass_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL simul_step: vld=%b ev=%h pass=%0d, want 1/00BBB/1", ev_out_vld, ev_out, pass_cnt);
    end
    @(negedge clk);
    score_vld = 1'b0;
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h00CCC || pass_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL simul_third: vld=%b ev=%h pass=%0d, want 1/00CCC/2", ev_out_vld, ev_out, pass_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (ev_out_vld !== 1'b0 || pass_cnt !== 16'd3 || err_overflow !== 1'b0 || err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_end: vld=%b pass=%0d ovf=%b orph=%b, want 0/3/0/0",
               ev_out_vld, pass_cnt, err_overflow, err_orphan);
    end
  endtask

  task automatic test_errors;
    logic [18:0] got [9];
    int n = 0;
    do_reset();
    send_score(16'd1, 16'd0);
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1 || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL err_orphan_empty: orph=%b ovf=%b, want 1/0", err_orphan, err_overflow);
    end
    do_reset();
    n_checks++;
    if (err_orphan !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL err_clear1: orph=%b ovf=%b, want 0/0", err_orphan, err_overflow);
    end
    ev_in = 19'h00DDD; ev_in_vld = 1'b1;
    score = 16'd1; threshold = 16'd0; score_vld = 1'b1;
    @(negedge clk);
    ev_in_vld = 1'b0; score_vld = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b1 || ev_out_vld !== 1'b0) begin
      n_fail++; $display("FAIL err_orphan_same: orph=%b vld=%b, want 1/0", err_orphan, ev_out_vld);
    end
    do_reset();
    for (int i = 0; i < 9; i++) push_ev(19'h00200 + 19'(i));
    n_checks++;
    if (err_overflow !== 1'b1 || err_orphan !== 1'b0 || ev_in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_overflow: ovf=%b orph=%b rdy=%b, want 1/0/0", err_overflow, err_orphan, ev_in_rdy);
    end
    score = 16'd3; threshold = 16'd0; score_vld = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (ev_out_vld === 1'b1 && n < 9) begin got[n] = ev_out; n++; end
      @(negedge clk);
    end
    score_vld = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ev_out_vld === 1'b1 && n < 9) begin got[n] = ev_out; n++; end
      @(negedge clk);
    end
    n_checks++;
    if (n != 8) begin
      n_fail++; $display("FAIL overflow_count: got %0d events, want 8", n);
    end
    for (int k = 0; k < 8 && k < n; k++) begin
      n_checks++;
      if (got[k] !== 19'h00200 + 19'(k)) begin
        n_fail++; $display("FAIL overflow_val%0d: ev=%h, want %h", k, got[k], 19'h00200 + 19'(k));
      end
    end
    n_checks++;
    if (err_overflow !== 1'b1 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky: ovf=%b orph=%b, want 1/0", err_overflow, err_orphan);
    end
    do_reset();
    n_checks++;
    if (err_orphan !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL err_clear2: orph=%b ovf=%b, want 0/0", err_orphan, err_overflow);
    end
  endtask

  task automatic test_bypass;
    do_reset();
    bypass = 1'b1;
    push_ev(19'h54321);
    send_score(16'h8000, 16'd0);
    n_checks++;
    if (ev_out_vld !== 1'b1 || ev_out !== 19'h54321) begin
      n_fail++; $display("FAIL bypass_out: vld=%b ev=%h, want 1/54321", ev_out_vld, ev_out);
    end
    @(negedge clk);
    n_checks++;
    if (pass_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL bypass_cnt: pass=%0d drop=%0d, want 1/0", pass_cnt, drop_cnt);
    end
    bypass = 1'b0;
  endtask

  task automatic test_saturation;
    do_reset();
    ev_in = 19'h00055; ev_in_vld = 1'b1;
    score = 16'hFFFF; threshold = 16'd0;
    @(negedge clk);
    score_vld = 1'b1;
    repeat (65540) @(negedge clk);
    ev_in_vld = 1'b0;
    @(negedge clk);
    score_vld = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (drop_cnt !== 16'hFFFF || pass_cnt !== 16'd0) begin
      n_fail++; $display("FAIL sat_drop: drop=%h pass=%h, want FFFF/0000", drop_cnt, pass_cnt);
    end
    n_checks++;
    if (err_overflow !== 1'b0 || err_orphan !== 1'b0 || ev_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_flags: ovf=%b orph=%b rdy=%b, want 0/0/1", err_overflow, err_orphan, ev_in_rdy);
    end
  endtask

  initial begin
    rst_n = 1'b0; ev_in = '0; ev_in_vld = 1'b0; score = '0; score_vld = 1'b0;
    threshold = '0; bypass = 1'b0; ev_out_rdy = 1'b1;
    test_reset();
    test_single_pass();
    test_noise_drop();
    test_ordering();
    test_simultaneous();
    test_errors();
    test_bypass();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dnd_event_gate.md
Name: dnd_event_gate

Overview:
- Downstream stage of the DVS denoise MLP top. Buffers each CAVIAR event the top accepts, pairs it in order with the MLP score that the top emits later, and compares the score against a runtime threshold.
- Forwards signal events on a valid/ready stream and discards noise events.
- Keeps pass/drop statistics and sticky error flags for software readout.

Parameters:
- CAVIAR_X_Y_BITS, 9, x/y field width; event word width W_EV = 2*CAVIAR_X_Y_BITS+1 (19).
- W_Y, 16, MLP score width; two's-complement signed.
- DEPTH, 8, event buffer entries; power of 2, >=2.
- W_CNT, 16, statistics counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ev_in  in  W_EV  CAVIAR event word, identical to the word presented to the MLP top.
- ev_in_vld  in  1  event accepted by the MLP top this cycle.
- ev_in_rdy  out  1  buffer not full; upstream asserts ev_in_vld only when high.
- score  in  W_Y  MLP output.
- score_vld  in  1  score valid, single-cycle pulse; cannot be back-pressured.
- threshold  in  W_Y  signed pass threshold, sampled in the score_vld cycle.
- bypass  in  1  1 = every event passes regardless of score.
- ev_out  out  W_EV  passed event.
- ev_out_vld  out  1  ev_out valid.
- ev_out_rdy  in  1  downstream ready.
- pass_cnt  out  W_CNT  events forwarded; saturating.
- drop_cnt  out  W_CNT  events discarded as noise; saturating.
- err_overflow  out  1  sticky: ev_in_vld seen while full.
- err_orphan  out  1  sticky: score_vld seen with no undecided entry.

Behaviour:
- Storage: DEPTH register entries {event, decided, pass}. Three pointers of log2(DEPTH)+1 bits:
  - wr_ptr: push position.
  - sc_ptr: oldest undecided entry.
  - rd_ptr: head.
  - Invariant: rd_ptr <= sc_ptr <= wr_ptr (modular). All pointers wrap naturally.
- Derived signals:
  - full when wr_ptr - rd_ptr == DEPTH.
  - undecided_cnt = wr_ptr - sc_ptr.
- ev_in_rdy = !full, from current-cycle registers only. No same-cycle pop credit: with full and a head pop in the same cycle, rdy stays low that cycle.
- Push: ev_in_vld && !full writes {ev_in, decided=0}, then wr_ptr++.
  - ev_in_vld && full: event discarded, err_overflow set. Score alignment is not guaranteed afterwards; no recovery beyond reset.
- Decide: score_vld && undecided_cnt != 0 writes entry[sc_ptr].decided = 1 and entry[sc_ptr].pass = bypass | ($signed(score) >= $signed(threshold)), then sc_ptr++.
  - Comparison is full W_Y signed; equal to threshold passes.
  - score_vld && undecided_cnt == 0: score discarded, err_orphan set.
  - An event pushed in the same cycle is not yet visible, so a score cannot decide it; this is also an orphan.
- Head, evaluated on registered state:
  - Head decided && pass: ev_out = head event, ev_out_vld = 1. On ev_out_vld && ev_out_rdy, pop (rd_ptr++) and pass_cnt++.
  - Head decided && !pass: ev_out_vld = 0, auto-pop that cycle, drop_cnt++.
  - Empty or head undecided: ev_out_vld = 0, no pop.
  - At most one pop per cycle.
- ev_out and ev_out_vld hold stable while ev_out_vld && !ev_out_rdy.
- Latency: score_vld in cycle t; the decision is visible at head in t+1 if that entry is the head. ev_out_vld rises in t+1, or the drop occurs in t+1.
- Push, decide and pop may all occur in the same cycle and are independent.
- Counters saturate at 2^W_CNT-1 and are cleared only by reset.
- ev_out is 0 when ev_out_vld is 0.
- Reset (async assert, sync-safe deassert):
  - pointers 0, counters 0, flags 0.
  - ev_out_vld 0, ev_out 0.
  - ev_in_rdy 1 one cycle after deassert.
  - Entry contents are don't-care; decided bits are cleared.
  - Reset mid-operation discards all buffered events.

Test Plan:
- Single event: push ev 0x12345, then score_vld with score 100, threshold 50, 20 cycles later -> ev_out_vld=1 next cycle with ev_out 0x12345; pass_cnt=1.
- Noise drop: score -3 (0xFFFD), threshold 0 -> no ev_out_vld; drop_cnt=1; buffer empties in 1 cycle. Score exactly equal to threshold -> passes.
- Ordering/backpressure: push 8 events (full, ev_in_rdy=0), then scores alternate pass/fail with ev_out_rdy=0 -> nothing emitted until ready. Once ready rises, the 4 passing events emerge in push order, fails drop silently; pass_cnt=4, drop_cnt=4, ev_in_rdy returns to 1.
- Simultaneous: same cycle push new event, score decides the head, downstream pops the prior head -> all three take effect; no loss, no error flags.
- Errors: score_vld on an empty buffer -> err_orphan=1. Push while full -> err_overflow=1, event not stored. Both flags stay set until rst_n pulse, then read 0.
- bypass=1 with score -32768 -> event passes. Counter saturation: force 65536+ drops -> drop_cnt holds 0xFFFF.
